// File: rtl/pbg_serial_tx.sv
// Parity-bit generator and serial frame transmitter.
// Frame: start(0), data LSB-first, parity, stop(1).
module pbg_serial_tx #(
    parameter int DATA_W     = 4,
    parameter int PARITY_ODD = 0,
    parameter int BIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              tx,
    output logic              p,
    output logic              busy,
    output logic              done
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] sh_next;
    logic              last_cyc;
    logic              last_idx;

    assign sh_next  = shreg >> 1;
    assign last_cyc = (cnt == CW'(BIT_CYCLES - 1));
    assign last_idx = (idx == IW'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            tx    <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (valid) begin
                        shreg <= data;
                        p     <= (^data) ^ (PARITY_ODD != 0);
                        state <= START;
                        cnt   <= '0;
                        tx    <= 1'b0;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (last_cyc) begin
                        state <= DATA;
                        cnt   <= '0;
                        idx   <= '0;
                        tx    <= shreg[0];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (last_cyc) begin
                        cnt   <= '0;
                        shreg <= sh_next;
                        if (last_idx) begin
                            state <= PARITY;
                            tx    <= p;
                        end else begin
                            idx <= idx + IW'(1);
                            tx  <= sh_next[0];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PARITY: begin
                    if (last_cyc) begin
                        state <= STOP;
                        cnt   <= '0;
                        tx    <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    // done and ready rise together on the return to idle
                    if (last_cyc) begin
                        state <= IDLE;
                        cnt   <= '0;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    tx    <= 1'b1;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
